// File: rtl/rs_station.sv
// Reservation station for the ALU path of the Tomasulo core.
// It holds renamed ALU instructions and captures operands as the two CDBs
// broadcast them. Each cycle it issues the lowest-index ready entry to the ALU
// and allocates new instructions into the lowest-index free entry.
module rs_station #(
  parameter int RS_SIZE = 16,
  parameter int RS_BIT  = 4,
  parameter int ROB_BIT = 5,
  parameter int OP_W    = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               inst_valid,
  input  logic [OP_W-1:0]    inst_op,
  input  logic [ROB_BIT-1:0] inst_rob_id,
  input  logic [31:0]        inst_vj,
  input  logic [31:0]        inst_vk,
  input  logic [ROB_BIT-1:0] inst_qj,
  input  logic [ROB_BIT-1:0] inst_qk,
  input  logic               inst_has_qj,
  input  logic               inst_has_qk,
  input  logic               alu_cdb_valid,
  input  logic [ROB_BIT-1:0] alu_cdb_rob_id,
  input  logic [31:0]        alu_cdb_value,
  input  logic               lsb_cdb_valid,
  input  logic [ROB_BIT-1:0] lsb_cdb_rob_id,
  input  logic [31:0]        lsb_cdb_value,
  output logic               full,
  output logic               alu_valid,
  output logic [OP_W-1:0]    alu_op,
  output logic [31:0]        alu_v1,
  output logic [31:0]        alu_v2,
  output logic [ROB_BIT-1:0] alu_rob_id
);

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] has_qj_q, has_qj_d;
  logic [RS_SIZE-1:0] has_qk_q, has_qk_d;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [OP_W-1:0]    op_d  [RS_SIZE];
  logic [ROB_BIT-1:0] rob_q [RS_SIZE];
  logic [ROB_BIT-1:0] rob_d [RS_SIZE];
  logic [ROB_BIT-1:0] qj_q  [RS_SIZE];
  logic [ROB_BIT-1:0] qj_d  [RS_SIZE];
  logic [ROB_BIT-1:0] qk_q  [RS_SIZE];
  logic [ROB_BIT-1:0] qk_d  [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE];
  logic [31:0]        vj_d  [RS_SIZE];
  logic [31:0]        vk_q  [RS_SIZE];
  logic [31:0]        vk_d  [RS_SIZE];

  logic               alu_valid_q, alu_valid_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [31:0]        alu_v1_q, alu_v1_d;
  logic [31:0]        alu_v2_q, alu_v2_d;
  logic [ROB_BIT-1:0] alu_rob_id_q, alu_rob_id_d;

  logic [RS_SIZE-1:0] prepared;
  logic               issue_found;
  logic [RS_BIT-1:0]  issue_idx;
  logic [RS_BIT-1:0]  free_idx;

  assign full       = &busy_q;
  assign prepared   = busy_q & ~has_qj_q & ~has_qk_q;
  assign alu_valid  = alu_valid_q;
  assign alu_op     = alu_op_q;
  assign alu_v1     = alu_v1_q;
  assign alu_v2     = alu_v2_q;
  assign alu_rob_id = alu_rob_id_q;

  // Priority choosers: scanning downward leaves the lowest matching index.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    free_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (prepared[i]) begin
        issue_found = 1'b1;
        issue_idx   = RS_BIT'(i);
      end
      if (!busy_q[i]) begin
        free_idx = RS_BIT'(i);
      end
    end
  end

  // Next state: wakeup from the CDBs, issue, then allocate the dispatched op.
  always_comb begin
    busy_d       = busy_q;
    has_qj_d     = has_qj_q;
    has_qk_d     = has_qk_q;
    op_d         = op_q;
    rob_d        = rob_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    alu_valid_d  = 1'b0;
    alu_op_d     = alu_op_q;
    alu_v1_d     = alu_v1_q;
    alu_v2_d     = alu_v2_q;
    alu_rob_id_d = alu_rob_id_q;
    if (rdy_in) begin
      if (clear) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && has_qj_q[i]) begin
            if (alu_cdb_valid && alu_cdb_rob_id == qj_q[i]) begin
              vj_d[i]     = alu_cdb_value;
              has_qj_d[i] = 1'b0;
            end else if (lsb_cdb_valid && lsb_cdb_rob_id == qj_q[i]) begin
              vj_d[i]     = lsb_cdb_value;
              has_qj_d[i] = 1'b0;
            end
          end
          if (busy_q[i] && has_qk_q[i]) begin
            if (alu_cdb_valid && alu_cdb_rob_id == qk_q[i]) begin
              vk_d[i]     = alu_cdb_value;
              has_qk_d[i] = 1'b0;
            end else if (lsb_cdb_valid && lsb_cdb_rob_id == qk_q[i]) begin
              vk_d[i]     = lsb_cdb_value;
              has_qk_d[i] = 1'b0;
            end
          end
        end
        if (issue_found) begin
          alu_valid_d       = 1'b1;
          alu_op_d          = op_q[issue_idx];
          alu_v1_d          = vj_q[issue_idx];
          alu_v2_d          = vk_q[issue_idx];
          alu_rob_id_d      = rob_q[issue_idx];
          busy_d[issue_idx] = 1'b0;
        end
        if (inst_valid && !full) begin
          busy_d[free_idx]   = 1'b1;
          op_d[free_idx]     = inst_op;
          rob_d[free_idx]    = inst_rob_id;
          qj_d[free_idx]     = inst_qj;
          qk_d[free_idx]     = inst_qk;
          vj_d[free_idx]     = inst_vj;
          vk_d[free_idx]     = inst_vk;
          has_qj_d[free_idx] = inst_has_qj;
          has_qk_d[free_idx] = inst_has_qk;
          if (inst_has_qj) begin
            if (alu_cdb_valid && alu_cdb_rob_id == inst_qj) begin
              vj_d[free_idx]     = alu_cdb_value;
              has_qj_d[free_idx] = 1'b0;
            end else if (lsb_cdb_valid && lsb_cdb_rob_id == inst_qj) begin
              vj_d[free_idx]     = lsb_cdb_value;
              has_qj_d[free_idx] = 1'b0;
            end
          end
          if (inst_has_qk) begin
            if (alu_cdb_valid && alu_cdb_rob_id == inst_qk) begin
              vk_d[free_idx]     = alu_cdb_value;
              has_qk_d[free_idx] = 1'b0;
            end else if (lsb_cdb_valid && lsb_cdb_rob_id == inst_qk) begin
              vk_d[free_idx]     = lsb_cdb_value;
              has_qk_d[free_idx] = 1'b0;
            end
          end
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q       <= '0;
      has_qj_q     <= '0;
      has_qk_q     <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
      end
      alu_valid_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_v1_q     <= '0;
      alu_v2_q     <= '0;
      alu_rob_id_q <= '0;
    end else begin
      busy_q       <= busy_d;
      has_qj_q     <= has_qj_d;
      has_qk_q     <= has_qk_d;
      op_q         <= op_d;
      rob_q        <= rob_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      alu_valid_q  <= alu_valid_d;
      alu_op_q     <= alu_op_d;
      alu_v1_q     <= alu_v1_d;
      alu_v2_q     <= alu_v2_d;
      alu_rob_id_q <= alu_rob_id_d;
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: a slot-level reference model plus
// directed scenarios with literal expectations.
module tb_rs_station;
  localparam int RS_SIZE = 16;
  localparam int ROB_BIT = 5;
  localparam int OP_W    = 6;

  logic               clk_in = 1'b0;
  logic               rst_in, rdy_in, clear;
  logic               inst_valid;
  logic [OP_W-1:0]    inst_op;
  logic [ROB_BIT-1:0] inst_rob_id, inst_qj, inst_qk;
  logic [31:0]        inst_vj, inst_vk;
  logic               inst_has_qj, inst_has_qk;
  logic               alu_cdb_valid, lsb_cdb_valid;
  logic [ROB_BIT-1:0] alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0]        alu_cdb_value, lsb_cdb_value;
  logic               full, alu_valid;
  logic [OP_W-1:0]    alu_op;
  logic [31:0]        alu_v1, alu_v2;
  logic [ROB_BIT-1:0] alu_rob_id;

  int checks = 0;
  int errors = 0;

  rs_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .inst_valid(inst_valid), .inst_op(inst_op), .inst_rob_id(inst_rob_id),
    .inst_vj(inst_vj), .inst_vk(inst_vk), .inst_qj(inst_qj), .inst_qk(inst_qk),
    .inst_has_qj(inst_has_qj), .inst_has_qk(inst_has_qk),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id),
    .alu_cdb_value(alu_cdb_value), .lsb_cdb_valid(lsb_cdb_valid),
    .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
    .full(full), .alu_valid(alu_valid), .alu_op(alu_op), .alu_v1(alu_v1),
    .alu_v2(alu_v2), .alu_rob_id(alu_rob_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [OP_W-1:0] op,
                               input logic [ROB_BIT-1:0] rob,
                               input logic [31:0] vj, input logic [31:0] vk,
                               input logic [ROB_BIT-1:0] qj, input logic hqj,
                               input logic [ROB_BIT-1:0] qk, input logic hqk);
    inst_valid  = v;
    inst_op     = op;
    inst_rob_id = rob;
    inst_vj     = vj;
    inst_vk     = vk;
    inst_qj     = qj;
    inst_has_qj = hqj;
    inst_qk     = qk;
    inst_has_qk = hqk;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
    alu_cdb_valid  = 1'b0;
    alu_cdb_rob_id = '0;
    alu_cdb_value  = '0;
    lsb_cdb_valid  = 1'b0;
    lsb_cdb_rob_id = '0;
    lsb_cdb_value  = '0;
    clear          = 1'b0;
  endtask

  // Reference model: a table of slots updated once per clock edge
  typedef struct {
    bit               busy;
    bit [OP_W-1:0]    op;
    bit [ROB_BIT-1:0] rob;
    bit [31:0]        vj, vk;
    bit [ROB_BIT-1:0] qj, qk;
    bit               hj, hk;
  } slot_t;

  slot_t            m [RS_SIZE];
  bit               m_valid;
  bit [OP_W-1:0]    m_op;
  bit [31:0]        m_v1, m_v2;
  bit [ROB_BIT-1:0] m_rob;
  bit               model_live = 1'b0;

  function automatic bit snoop(input bit [ROB_BIT-1:0] tag, output bit [31:0] val);
    val = '0;
    if (alu_cdb_valid && alu_cdb_rob_id == tag) begin
      val = alu_cdb_value;
      return 1'b1;
    end
    if (lsb_cdb_valid && lsb_cdb_rob_id == tag) begin
      val = lsb_cdb_value;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk_in) begin
    int iss;
    int fre;
    bit [31:0] v;
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
      m_valid = 1'b0; m_op = '0; m_v1 = '0; m_v2 = '0; m_rob = '0;
      model_live = 1'b1;
    end else if (!rdy_in) begin
      m_valid = 1'b0;
    end else if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
      m_valid = 1'b0;
    end else begin
      iss = -1;
      fre = -1;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (iss < 0 && m[i].busy && !m[i].hj && !m[i].hk) iss = i;
        if (fre < 0 && !m[i].busy) fre = i;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (m[i].busy && m[i].hj && snoop(m[i].qj, v)) begin m[i].vj = v; m[i].hj = 1'b0; end
        if (m[i].busy && m[i].hk && snoop(m[i].qk, v)) begin m[i].vk = v; m[i].hk = 1'b0; end
      end
      m_valid = (iss >= 0);
      if (iss >= 0) begin
        m_op = m[iss].op; m_v1 = m[iss].vj; m_v2 = m[iss].vk; m_rob = m[iss].rob;
        m[iss].busy = 1'b0;
      end
      if (inst_valid && fre >= 0) begin
        m[fre].busy = 1'b1;
        m[fre].op = inst_op; m[fre].rob = inst_rob_id;
        m[fre].vj = inst_vj; m[fre].vk = inst_vk;
        m[fre].qj = inst_qj; m[fre].qk = inst_qk;
        m[fre].hj = inst_has_qj; m[fre].hk = inst_has_qk;
        if (inst_has_qj && snoop(inst_qj, v)) begin m[fre].vj = v; m[fre].hj = 1'b0; end
        if (inst_has_qk && snoop(inst_qk, v)) begin m[fre].vk = v; m[fre].hk = 1'b0; end
      end
    end
  end

  // Compare the DUT against the model on every falling edge
  always @(negedge clk_in) begin
    int nb;
    if (model_live) begin
      nb = 0;
      for (int i = 0; i < RS_SIZE; i++) if (m[i].busy) nb++;
      checkOutput("model_full", {31'd0, full}, {31'd0, nb == RS_SIZE});
      checkOutput("model_alu_valid", {31'd0, alu_valid}, {31'd0, m_valid});
      if (m_valid) begin
        checkOutput("model_alu_op", 32'(alu_op), 32'(m_op));
        checkOutput("model_alu_v1", alu_v1, m_v1);
        checkOutput("model_alu_v2", alu_v2, m_v2);
        checkOutput("model_alu_rob_id", 32'(alu_rob_id), 32'(m_rob));
      end
    end
  end

  // Directed scenarios with hand-computed expectations
  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    repeat (3) @(negedge clk_in);
    checkOutput("reset_valid", {31'd0, alu_valid}, 32'd0);
    checkOutput("reset_op", 32'(alu_op), 32'd0);
    checkOutput("reset_v1", alu_v1, 32'd0);
    checkOutput("reset_v2", alu_v2, 32'd0);
    checkOutput("reset_rob", 32'(alu_rob_id), 32'd0);
    checkOutput("reset_full", {31'd0, full}, 32'd0);
    rst_in = 1'b0;

    // Simple ready ADD
    applyStimulus(1'b1, 6'h01, 5'd3, 32'd5, 32'd7, '0, 1'b0, '0, 1'b0);
    @(negedge clk_in); idle();
    checkOutput("add_not_yet", {31'd0, alu_valid}, 32'd0);
    @(negedge clk_in);
    checkOutput("add_valid", {31'd0, alu_valid}, 32'd1);
    checkOutput("add_op", 32'(alu_op), 32'h01);
    checkOutput("add_v1", alu_v1, 32'd5);
    checkOutput("add_v2", alu_v2, 32'd7);
    checkOutput("add_rob", 32'(alu_rob_id), 32'd3);
    @(negedge clk_in);
    checkOutput("add_pulse_end", {31'd0, alu_valid}, 32'd0);

    // Wakeup by ALU CDB
    applyStimulus(1'b1, 6'h02, 5'd4, 32'd0, 32'd1, 5'd2, 1'b1, '0, 1'b0);
    @(negedge clk_in); idle();
    checkOutput("wake_wait", {31'd0, alu_valid}, 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 5'd2; alu_cdb_value = 32'h10;
    @(negedge clk_in); idle();
    checkOutput("wake_latency", {31'd0, alu_valid}, 32'd0);
    @(negedge clk_in);
    checkOutput("wake_valid", {31'd0, alu_valid}, 32'd1);
    checkOutput("wake_v1", alu_v1, 32'h10);
    checkOutput("wake_v2", alu_v2, 32'd1);
    checkOutput("wake_rob", 32'(alu_rob_id), 32'd4);
    @(negedge clk_in);

    // Dispatch-time forwarding from the LSB CDB
    applyStimulus(1'b1, 6'h03, 5'd6, 32'd0, 32'd2, 5'd9, 1'b1, '0, 1'b0);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 5'd9; lsb_cdb_value = 32'hAA;
    @(negedge clk_in); idle();
    checkOutput("fwd_not_yet", {31'd0, alu_valid}, 32'd0);
    @(negedge clk_in);
    checkOutput("fwd_valid", {31'd0, alu_valid}, 32'd1);
    checkOutput("fwd_v1", alu_v1, 32'hAA);
    checkOutput("fwd_rob", 32'(alu_rob_id), 32'd6);
    @(negedge clk_in);

    // Fill all entries, then release them with one broadcast
    for (int i = 0; i < RS_SIZE; i++) begin
      applyStimulus(1'b1, 6'h04, 5'(10 + i), 32'd0, 32'(i), 5'd1, 1'b1, '0, 1'b0);
      @(negedge clk_in);
    end
    checkOutput("fill_full", {31'd0, full}, 32'd1);
    applyStimulus(1'b1, 6'h05, 5'd30, 32'd1, 32'd1, '0, 1'b0, '0, 1'b0);
    @(negedge clk_in); idle();
    checkOutput("fill_17th_full", {31'd0, full}, 32'd1);
    checkOutput("fill_17th_no_issue", {31'd0, alu_valid}, 32'd0);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 5'd1; lsb_cdb_value = 32'h55;
    @(negedge clk_in); idle();
    for (int i = 0; i < RS_SIZE; i++) begin
      @(negedge clk_in);
      checkOutput("drain_valid", {31'd0, alu_valid}, 32'd1);
      checkOutput("drain_rob", 32'(alu_rob_id), 32'(10 + i));
      checkOutput("drain_v2", alu_v2, 32'(i));
      if (i == 0) checkOutput("drain_full_drop", {31'd0, full}, 32'd0);
    end
    @(negedge clk_in);
    checkOutput("drain_done", {31'd0, alu_valid}, 32'd0);

    // Entries 2 and 5 become ready together
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 6'h06, 5'(20 + i), 32'd0, 32'd0,
                    (i == 2 || i == 5) ? 5'd7 : 5'd8, 1'b1, '0, 1'b0);
      @(negedge clk_in);
    end
    idle();
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 5'd7; alu_cdb_value = 32'h77;
    @(negedge clk_in); idle();
    @(negedge clk_in);
    checkOutput("prio_first", 32'(alu_rob_id), 32'd22);
    @(negedge clk_in);
    checkOutput("prio_second", 32'(alu_rob_id), 32'd25);
    @(negedge clk_in);
    checkOutput("prio_done", {31'd0, alu_valid}, 32'd0);

    // Clear with busy entries and a concurrent dispatch
    clear = 1'b1;
    applyStimulus(1'b1, 6'h07, 5'd31, 32'd1, 32'd2, '0, 1'b0, '0, 1'b0);
    @(negedge clk_in); idle();
    checkOutput("clear_full", {31'd0, full}, 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 5'd8; alu_cdb_value = 32'h88;
    @(negedge clk_in); idle();
    repeat (4) begin
      @(negedge clk_in);
      checkOutput("clear_no_issue", {31'd0, alu_valid}, 32'd0);
    end

    // Stall with rdy_in low, including an ignored dispatch
    applyStimulus(1'b1, 6'h08, 5'd12, 32'd9, 32'd8, '0, 1'b0, '0, 1'b0);
    @(negedge clk_in);
    rdy_in = 1'b0;
    applyStimulus(1'b1, 6'h09, 5'd13, 32'd1, 32'd1, '0, 1'b0, '0, 1'b0);
    @(negedge clk_in); idle();
    checkOutput("stall_no_issue", {31'd0, alu_valid}, 32'd0);
    @(negedge clk_in);
    checkOutput("stall_hold", {31'd0, alu_valid}, 32'd0);
    rdy_in = 1'b1;
    @(negedge clk_in);
    checkOutput("stall_resume", {31'd0, alu_valid}, 32'd1);
    checkOutput("stall_rob", 32'(alu_rob_id), 32'd12);
    @(negedge clk_in);
    checkOutput("stall_dropped", {31'd0, alu_valid}, 32'd0);

    // Reset mid-stream while an issue is due
    applyStimulus(1'b1, 6'h0A, 5'd14, 32'd3, 32'd4, '0, 1'b0, '0, 1'b0);
    @(negedge clk_in); idle();
    rst_in = 1'b1;
    @(negedge clk_in);
    checkOutput("mid_reset_valid", {31'd0, alu_valid}, 32'd0);
    checkOutput("mid_reset_op", 32'(alu_op), 32'd0);
    checkOutput("mid_reset_v1", alu_v1, 32'd0);
    checkOutput("mid_reset_v2", alu_v2, 32'd0);
    checkOutput("mid_reset_rob", 32'(alu_rob_id), 32'd0);
    checkOutput("mid_reset_full", {31'd0, full}, 32'd0);
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("post_reset_idle", {31'd0, alu_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
